// File: rtl/q_pkg.sv
// Shared definitions for the charge-measurement chain.
// Holds the averager FSM state type and the default bus width and window size.
// The upstream measurement stage uses the same defaults.
package q_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } q_state_e;

  localparam int unsigned Q_BUS_WIDTH    = 10;
  localparam int unsigned Q_LOG2_SAMPLES = 2;

endpackage

// File: rtl/q_averager_if.sv
// Measurement / result bus between the charge-measurement stage, the averager
// and the result consumer.
//   meas_ready, q_measured : upstream measurement flag and value
//   avg_ack                : consumer acknowledge of the averaged result
//   avg_valid, avg_q       : averaged result and its valid flag
//   q_min, q_max           : window minimum / maximum
//   overrun                : sticky dropped-measurement flag
// master = environment side, slave = averager side.
interface q_averager_if #(
  parameter int unsigned BUS_WIDTH = q_pkg::Q_BUS_WIDTH
);
  logic                 meas_ready;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 avg_ack;
  logic                 avg_valid;
  logic [BUS_WIDTH-1:0] avg_q;
  logic [BUS_WIDTH-1:0] q_min;
  logic [BUS_WIDTH-1:0] q_max;
  logic                 overrun;

  modport master (
    output meas_ready, q_measured, avg_ack,
    input  avg_valid, avg_q, q_min, q_max, overrun
  );

  modport slave (
    input  meas_ready, q_measured, avg_ack,
    output avg_valid, avg_q, q_min, q_max, overrun
  );
endinterface

// File: rtl/q_averager_rise_detect.sv
// Rising-edge detector.
//   clk, rst : clock, synchronous active-high reset
//   in       : level input
//   pulse    : high for the cycle where in=1 and the previous cycle had in=0
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic in_q;
  logic in_d;

  always_comb begin
    in_d  = in;
    pulse = in & ~in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_d;
  end
endmodule

// File: rtl/q_averager.sv
// Windowed averager for charge measurements.
// Accumulates 2**LOG2_SAMPLES captures (rising edges of meas_ready), then
// presents the truncated average plus window min/max until acknowledged.
//   clk, rst : clock, synchronous active-high reset (highest priority)
//   start    : enable; low clears everything on the next cycle
//   bus      : measurement input, result output and handshake (slave side)
module q_averager
  import q_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = Q_BUS_WIDTH,
  parameter int unsigned LOG2_SAMPLES = Q_LOG2_SAMPLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  q_averager_if.slave  bus
);
  localparam int unsigned SUM_W = BUS_WIDTH + LOG2_SAMPLES;
  localparam int unsigned CNT_W = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << LOG2_SAMPLES;

  q_state_e             state_q, state_d;
  logic [SUM_W-1:0]     sum_q, sum_d, sum_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_nxt;
  logic [BUS_WIDTH-1:0] min_q, min_d, min_nxt;
  logic [BUS_WIDTH-1:0] max_q, max_d, max_nxt;
  logic                 avg_valid_q, avg_valid_d;
  logic [BUS_WIDTH-1:0] avg_q_q, avg_q_d;
  logic [BUS_WIDTH-1:0] q_min_q, q_min_d;
  logic [BUS_WIDTH-1:0] q_max_q, q_max_d;
  logic                 overrun_q, overrun_d;
  logic                 cap;
  logic                 accept;

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.meas_ready),
    .pulse (cap)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    avg_valid_d = avg_valid_q;
    avg_q_d     = avg_q_q;
    q_min_d     = q_min_q;
    q_max_d     = q_max_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;

    sum_nxt = sum_q + SUM_W'(bus.q_measured);
    cnt_nxt = cnt_q + CNT_W'(1);
    min_nxt = (bus.q_measured < min_q) ? bus.q_measured : min_q;
    max_nxt = (bus.q_measured > max_q) ? bus.q_measured : max_q;

    unique case (state_q)
      IDLE: begin
        sum_d = '0;
        cnt_d = '0;
        min_d = '1;
        max_d = '0;
        if (start) state_d = ACCUM;
      end
      ACCUM: accept = cap;
      HOLD: begin
        if (bus.avg_ack) begin
          avg_valid_d = 1'b0;
          state_d     = ACCUM;
          // Trackers were cleared on entry to HOLD, so a coincident capture
          // starts the next window directly.
          accept      = cap;
        end else if (cap) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (cnt_nxt == N_SAMPLES) begin
        avg_q_d     = BUS_WIDTH'(sum_nxt >> LOG2_SAMPLES);
        q_min_d     = min_nxt;
        q_max_d     = max_nxt;
        avg_valid_d = 1'b1;
        state_d     = HOLD;
        sum_d       = '0;
        cnt_d       = '0;
        min_d       = '1;
        max_d       = '0;
      end else begin
        sum_d = sum_nxt;
        cnt_d = cnt_nxt;
        min_d = min_nxt;
        max_d = max_nxt;
      end
    end

    if (!start) begin
      state_d     = IDLE;
      sum_d       = '0;
      cnt_d       = '0;
      min_d       = '1;
      max_d       = '0;
      avg_valid_d = 1'b0;
      avg_q_d     = '0;
      q_min_d     = '0;
      q_max_d     = '0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_q_q     <= '0;
      q_min_q     <= '0;
      q_max_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      avg_valid_q <= avg_valid_d;
      avg_q_q     <= avg_q_d;
      q_min_q     <= q_min_d;
      q_max_q     <= q_max_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_q     = avg_q_q;
  assign bus.q_min     = q_min_q;
  assign bus.q_max     = q_max_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: doc/q_averager.md
Q_AVERAGER -- requirements
Module: q_averager

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 10: width of each charge measurement and of the averaged result.
REQ-002 SHALL have parameter LOG2_SAMPLES, default 2: window size N = 2**LOG2_SAMPLES measurements; legal range 0..6.
REQ-003 SHALL have port clk, input, 1: single clock for all logic; one clock only.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: enable; low acts as synchronous clear, the same convention the upstream measurement stage uses.
REQ-006 SHALL have port meas_ready, input, 1: ready flag from the upstream charge-measurement stage.
REQ-007 SHALL have port q_measured, input, BUS_WIDTH: measured charge, valid when meas_ready rises.
REQ-008 SHALL have port avg_ack, input, 1: consumer acknowledge of the averaged result.
REQ-009 SHALL have port avg_valid, output, 1: averaged result available.
REQ-010 SHALL have port avg_q, output, BUS_WIDTH: window average.
REQ-011 SHALL have port q_min, output, BUS_WIDTH: window minimum.
REQ-012 SHALL have port q_max, output, BUS_WIDTH: window maximum.
REQ-013 SHALL have port overrun, output, 1: sticky flag, a measurement was dropped.

Function
REQ-014 SHALL register meas_ready and define a capture event as meas_ready=1 with previous-cycle meas_ready=0; q_measured is sampled in that same cycle; a held-high meas_ready yields exactly one capture.
REQ-015 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-016 IDLE: sum, count, min and max trackers are cleared; captures are ignored; when start=1, the FSM moves to ACCUM on the next cycle.
REQ-017 ACCUM: on each capture, sum += q_measured, count += 1, and the min/max trackers update; the sum is BUS_WIDTH+LOG2_SAMPLES bits wide and cannot overflow.
REQ-018 ACCUM: on the capture that makes count = N, the next cycle SHALL load avg_q = (sum including that sample) >> LOG2_SAMPLES (truncating) and load q_min/q_max, assert avg_valid, and enter HOLD; latency is 1 cycle from the Nth capture.
REQ-019 HOLD: avg_valid, avg_q, q_min and q_max SHALL stay stable until avg_ack=1 is sampled.
REQ-020 HOLD: on avg_ack=1, avg_valid SHALL deassert on the next cycle, the trackers clear, and the FSM returns to ACCUM.
REQ-021 A capture in the same cycle as an accepted avg_ack SHALL be accepted as sample 1 of the next window.
REQ-022 A capture in HOLD without ack SHALL be dropped and SHALL set overrun; overrun clears only on rst or start=0.
REQ-023 avg_ack while avg_valid=0 SHALL be ignored.
REQ-024 start=0 in any state SHALL force, on the next cycle: IDLE, avg_valid=0, all outputs 0, partial window discarded.
REQ-025 rst and start=0 asserted together SHALL behave as rst; rst has priority over every other input.
REQ-026 When N=1 (LOG2_SAMPLES=0), every capture SHALL produce a result, with avg_q = q_min = q_max = sample.

Reset
REQ-027 On rst: state=IDLE, avg_valid=0, avg_q=0, q_min=0, q_max=0, overrun=0, sum=0, count=0, edge register=0.
REQ-028 Internal min tracker SHALL be initialised to all-ones and max tracker to 0 at every window start.

Structure
REQ-029 Shared package q_pkg SHALL hold the FSM state typedef (IDLE/ACCUM/HOLD) and default BUS_WIDTH and LOG2_SAMPLES constants, shared with the upstream measurement stage.
REQ-030 Rising-edge detection SHALL be a sub-module named rise_detect (clk, rst, in, pulse); all other logic stays in q_averager.

Verification (BUS_WIDTH=10, LOG2_SAMPLES=2)
REQ-031 Captures 30,60,90,120 -> avg_valid rises 1 cycle after 4th capture; avg_q=75, q_min=30, q_max=120.
REQ-032 Captures 1023 x4 -> avg_q=1023, no wrap; captures 1,2,2,2 -> avg_q=1 (truncation).
REQ-033 meas_ready held high 5 cycles then low, repeated 4 times -> exactly 4 captures, one result.
REQ-034 Result held without ack, 2 further captures -> overrun=1, avg_q unchanged; then ack -> avg_valid=0 next cycle, next window needs 4 fresh samples.
REQ-035 Ack coincident with a capture of 40, then captures 40,40,40 -> second result avg_q=40.
REQ-036 start=0 after 2 captures, then start=1 and 4 captures of 8 -> avg_q=8; rst mid-window -> all outputs 0 next cycle.
